// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between fetch and data requesters with in-order tagged replies.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed priority (data > inst).
module sram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    logic                  data_gnt, inst_gnt;
    logic [RD_LATENCY-1:0] vld_q, vld_d, own_q, own_d;
`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;
    // rr_last: 1 = data owned the last grant, so inst wins the next contention
    always_comb begin
        data_gnt  = !reset && data_req && !(inst_req && rr_last_q);
        rr_last_d = data_gnt ? 1'b1 : (inst_gnt ? 1'b0 : rr_last_q);
    end
    always_ff @(posedge clk) rr_last_q <= reset ? 1'b0 : rr_last_d;
`else
    always_comb data_gnt = !reset && data_req;
`endif
    always_comb begin
        inst_gnt     = !reset && inst_req && !data_gnt;
        vld_d        = (vld_q << 1) | RD_LATENCY'(inst_gnt || data_gnt);
        own_d        = (own_q << 1) | RD_LATENCY'(data_gnt);
        inst_addr_ok = inst_gnt;
        data_addr_ok = data_gnt;
        sram_en      = inst_gnt || data_gnt;
        sram_we      = (data_gnt && data_wr) ? data_wstrb : 4'b0;
        sram_addr    = data_gnt ? data_addr : inst_addr;
        sram_wdata   = data_gnt ? data_wdata : '0;
        inst_data_ok = !reset && vld_q[RD_LATENCY-1] && !own_q[RD_LATENCY-1];
        data_data_ok = !reset && vld_q[RD_LATENCY-1] && own_q[RD_LATENCY-1];
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter with a behavioural SRAM and reference memory.
// Build with ARB_RR_EN defined to check the round-robin variant.
module tb_sram_arbiter;
    localparam int LAT = 3;
`ifdef ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif
    logic        clk = 1'b0, reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb, sram_we;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        sram_en;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own;
        bit          wr;
        logic [31:0] data;
        int          due;
    } rep_t;

    rep_t        q[$];
    logic [31:0] ref_mem[logic [31:0]];
    int          checks = 0, errors = 0, cyc = 0;
    bit          rr_m = 1'b0, gi, gd;

    function automatic logic [31:0] ival(logic [31:0] a);
        return 32'hC0DE0000 ^ ({20'd0, a[11:0]} * 32'h00100401);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w, logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b+:8] = w[8*b+:8];
        return o;
    endfunction

    function automatic logic [31:0] rdref(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ival(a);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
        end
    endtask

    // Behavioural single-port SRAM, word indexed by addr[11:2], read data delayed LAT cycles
    logic [31:0] smem[0:1023];
    logic [31:0] rpipe[0:LAT-1];
    initial begin
        for (int i = 0; i < 1024; i++) smem[i] = ival({20'd0, i[9:0], 2'b00});
        smem[128] = 32'h11223344;
    end
    always @(posedge clk) begin
        if (sram_en && |sram_we) smem[sram_addr[11:2]] <= merge(smem[sram_addr[11:2]], sram_wdata, sram_we);
        rpipe[0] <= sram_en ? smem[sram_addr[11:2]] : 32'hDEADBEEF;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign sram_rdata = rpipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_grant();
        bit   ei, ed;
        rep_t e;
        gi = 1'b0;
        gd = 1'b0;
        if (reset) begin
            chk("reset_outputs", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, 0);
            return;
        end
        ed = data_req && !(RR_ON && inst_req && rr_m);
        ei = inst_req && !ed;
        chk("inst_addr_ok", inst_addr_ok, ei);
        chk("data_addr_ok", data_addr_ok, ed);
        chk("sram_en", sram_en, ei || ed);
        chk("sram_we", sram_we, (ed && data_wr) ? data_wstrb : 4'b0);
        if (ed) begin
            chk("sram_addr_data", sram_addr, data_addr);
            if (data_wr) chk("sram_wdata", sram_wdata, data_wdata);
            e = '{own: 1'b1, wr: data_wr, data: rdref(data_addr), due: cyc + LAT};
            if (data_wr) ref_mem[data_addr] = merge(e.data, data_wdata, data_wstrb);
            rr_m = 1'b1;
        end else if (ei) begin
            chk("sram_addr_inst", sram_addr, inst_addr);
            e = '{own: 1'b0, wr: 1'b0, data: rdref(inst_addr), due: cyc + LAT};
            rr_m = 1'b0;
        end else begin
            chk("idle_sram_addr", sram_addr, inst_addr);
        end
        if (ei || ed) q.push_back(e);
        gi = ei;
        gd = ed;
    endtask

    task automatic tick();
        @(negedge clk);
        check_grant();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_data(bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        data_req   = 1'b1;
        data_wr    = w;
        data_wstrb = s;
        data_addr  = a;
        data_wdata = d;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a reply
    always @(negedge clk) begin
        rep_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("reply_missing", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (!reset && (inst_data_ok || data_data_ok)) begin
            chk("one_reply", {inst_data_ok, data_data_ok}, inst_data_ok ? 2'b10 : 2'b01);
            if (q.size() == 0) chk("unexpected_reply", {inst_data_ok, data_data_ok}, 0);
            else begin
                e = q.pop_front();
                chk("reply_owner", data_data_ok, e.own);
                chk("reply_cycle", cyc, e.due);
                if (!e.wr) chk("reply_data", e.own ? data_rdata : inst_rdata, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        inst_req = 1'b0;
        inst_addr = 32'h1c000000;
        data_req = 1'b0;
        data_wr = 1'b0;
        data_wstrb = 4'h0;
        data_addr = 32'h0;
        data_wdata = 32'h0;
        ref_mem[32'h200] = 32'h11223344;
        inst_req = 1'b1;
        data_req = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        idle(1);
        // single fetch
        inst_req = 1'b1;
        inst_addr = 32'h1c000000;
        tick();
        idle(LAT + 1);
        // contention
        inst_req = 1'b1;
        inst_addr = 32'h1c000004;
        set_data(1'b0, 4'h0, 32'h100, 32'h0);
        tick();
        if (gd) data_req = 1'b0;
        if (gi) inst_req = 1'b0;
        tick();
        idle(LAT + 1);
        // byte write then read-back
        set_data(1'b1, 4'b0010, 32'h200, 32'hAABBCCDD);
        tick();
        set_data(1'b0, 4'h0, 32'h200, 32'h0);
        tick();
        idle(LAT + 1);
        // pipelined inst, data, inst
        inst_req = 1'b1;
        inst_addr = 32'h1c000008;
        tick();
        inst_req = 1'b0;
        set_data(1'b0, 4'h0, 32'h204, 32'h0);
        tick();
        data_req = 1'b0;
        inst_req = 1'b1;
        inst_addr = 32'h1c00000c;
        tick();
        idle(LAT + 1);
        // reset while a grant is in flight
        inst_req = 1'b1;
        inst_addr = 32'h1c000010;
        tick();
        inst_req = 1'b0;
        reset = 1'b1;
        q.delete();
        rr_m = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        idle(2);
        inst_req = 1'b1;
        inst_addr = 32'h1c000000;
        tick();
        idle(LAT + 1);
        // sustained contention, then inst alone
        inst_req = 1'b1;
        inst_addr = 32'h1c000014;
        set_data(1'b0, 4'h0, 32'h208, 32'h0);
        repeat (6) tick();
        data_req = 1'b0;
        repeat (4) tick();
        idle(LAT + 1);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!inst_req && $urandom_range(0, 2) != 0) begin
                inst_req = 1'b1;
                inst_addr = 32'h1c000000 + 4 * $urandom_range(0, 63);
            end
            if (!data_req && $urandom_range(0, 2) != 0)
                set_data(1'($urandom_range(0, 1)), 4'($urandom), 32'h200 + 4 * $urandom_range(0, 15), $urandom);
            tick();
            if (gi) inst_req = 1'b0;
            if (gd) data_req = 1'b0;
        end
        idle(LAT + 2);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
